bsg_link_sdr_downstream_sipo: RTL and testbench

//  Receive side of the upstream link channel pair: captures NUM_CHANNELS narrow io lanes,

---
 rtl/bsg_link_pkg.sv | 22 ++
 rtl/bsg_link_rx_fifo.sv | 60 ++++++
 rtl/bsg_link_sdr_downstream_sipo.sv | 105 ++++++++++
 tb/tb_bsg_link_sdr_downstream_sipo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_pkg.sv
// Shared parameters, types and sizing helpers for the link receive path.
package bsg_link_pkg;

  localparam int LINK_CHANNEL_WIDTH    = 8;
  localparam int LINK_NUM_CHANNELS     = 2;
  localparam int LINK_CORE_WIDTH       = 64;
  localparam int LINK_FIFO_DEPTH       = 8;
  localparam int LINK_TOKEN_DECIMATION = 2;

  // One beat across all lanes, lane 0 in the low bits.
  typedef logic [LINK_NUM_CHANNELS*LINK_CHANNEL_WIDTH-1:0] lane_beat_t;

  function automatic int beats_per_word(input int core_width, input int num_channels,
                                        input int channel_width);
    return core_width / (num_channels * channel_width);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bsg_link_rx_fifo.sv
// Word buffer between the SIPO assembler and the core; outputs depend only on flops.
module bsg_link_rx_fifo
  import bsg_link_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             full
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             empty, push_ok, pop_ok;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign valid    = !empty;
  assign data_out = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = data_in;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/bsg_link_sdr_downstream_sipo.sv
// Link receive path: reassembles lane beats into core words, buffers them, and
// returns one credit token per TOKEN_DECIMATION words consumed by the core.
module bsg_link_sdr_downstream_sipo
  import bsg_link_pkg::*;
#(
  parameter int CHANNEL_WIDTH    = LINK_CHANNEL_WIDTH,
  parameter int NUM_CHANNELS     = LINK_NUM_CHANNELS,
  parameter int CORE_WIDTH       = LINK_CORE_WIDTH,
  parameter int FIFO_DEPTH       = LINK_FIFO_DEPTH,
  parameter int TOKEN_DECIMATION = LINK_TOKEN_DECIMATION
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CHANNELS-1:0]               io_valid_i,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] io_data_i,
  output logic                                  io_token_o,
  output logic                                  core_valid_o,
  output logic [CORE_WIDTH-1:0]                 core_data_o,
  input  logic                                  core_ready_i,
  output logic                                  lane_err_o,
  output logic                                  overflow_o
);

  localparam int BEAT_BITS = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int BEATS     = beats_per_word(CORE_WIDTH, NUM_CHANNELS, CHANNEL_WIDTH);
  localparam int BEAT_W    = ptr_width(BEATS);
  localparam int TOK_W     = ptr_width(TOKEN_DECIMATION);

  logic [BEAT_W-1:0]     beat_ctr_q, beat_ctr_d;
  logic [CORE_WIDTH-1:0] asm_q, asm_d;
  logic [TOK_W-1:0]      tok_ctr_q, tok_ctr_d;
  logic                  token_q, token_d;
  logic                  lane_err_q, lane_err_d;
  logic                  overflow_q, overflow_d;
  logic                  all_valid, partial, last_beat, push, pop, fifo_full;

  assign all_valid = &io_valid_i;
  assign partial   = (|io_valid_i) && !all_valid;
  assign last_beat = (beat_ctr_q == BEAT_W'(BEATS - 1));
  assign push      = all_valid && last_beat;
  assign pop       = core_valid_o && core_ready_i;

  // asm_d already holds the final beat, so the FIFO is written from it directly.
  always_comb begin
    asm_d      = asm_q;
    beat_ctr_d = beat_ctr_q;
    tok_ctr_d  = tok_ctr_q;
    token_d    = 1'b0;
    lane_err_d = lane_err_q | partial;
    overflow_d = overflow_q | (push && fifo_full && !pop);
    if (all_valid) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_ctr_q == BEAT_W'(k)) begin
          asm_d[k*BEAT_BITS +: BEAT_BITS] = io_data_i;
        end
      end
      beat_ctr_d = last_beat ? '0 : beat_ctr_q + BEAT_W'(1);
    end
    if (pop) begin
      if (tok_ctr_q == TOK_W'(TOKEN_DECIMATION - 1)) begin
        tok_ctr_d = '0;
        token_d   = 1'b1;
      end else begin
        tok_ctr_d = tok_ctr_q + TOK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_ctr_q <= '0;
      asm_q      <= '0;
      tok_ctr_q  <= '0;
      token_q    <= 1'b0;
      lane_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      beat_ctr_q <= beat_ctr_d;
      asm_q      <= asm_d;
      tok_ctr_q  <= tok_ctr_d;
      token_q    <= token_d;
      lane_err_q <= lane_err_d;
      overflow_q <= overflow_d;
    end
  end

  bsg_link_rx_fifo #(
    .WIDTH(CORE_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .data_in (asm_d),
    .pop     (core_ready_i),
    .valid   (core_valid_o),
    .data_out(core_data_o),
    .full    (fifo_full)
  );

  assign io_token_o = token_q;
  assign lane_err_o = lane_err_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bsg_link_sdr_downstream_sipo.sv
// Directed scenario tests for the link receive path with hand-computed expectations.
module tb_bsg_link_sdr_downstream_sipo;
  import bsg_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  io_valid_i;
  lane_beat_t  io_data_i;
  logic        io_token_o;
  logic        core_valid_o;
  logic [63:0] core_data_o;
  logic        core_ready_i;
  logic        lane_err_o;
  logic        overflow_o;

  int checks = 0;
  int failures = 0;

  bsg_link_sdr_downstream_sipo dut (
    .clk         (clk),
    .rst         (rst),
    .io_valid_i  (io_valid_i),
    .io_data_i   (io_data_i),
    .io_token_o  (io_token_o),
    .core_valid_o(core_valid_o),
    .core_data_o (core_data_o),
    .core_ready_i(core_ready_i),
    .lane_err_o  (lane_err_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [1:0] v, input lane_beat_t d);
    io_valid_i = v;
    io_data_i  = d;
    tick();
    io_valid_i = 2'b00;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int k = 0; k < 4; k++) send_beat(2'b11, w[k*16 +: 16]);
  endtask

  task automatic do_reset;
    rst          = 1'b1;
    io_valid_i   = 2'b00;
    io_data_i    = '0;
    core_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] word_of(input int i);
    return {16'hC0DE, 16'(i), 16'hBEEF, 16'(i + 1)};
  endfunction

  task automatic test_reset;
    do_reset();
    checks++; if (core_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", core_valid_o); end
    checks++; if (core_data_o !== 64'h0) begin failures++; $display("[TB] FAIL rst_data got=%h exp=0", core_data_o); end
    checks++; if (io_token_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_token got=%b exp=0", io_token_o); end
    checks++; if (lane_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_lane_err got=%b exp=0", lane_err_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_overflow got=%b exp=0", overflow_o); end
  endtask

  task automatic test_basic_word;
    core_ready_i = 1'b1;
    send_beat(2'b11, 16'h1100);
    send_beat(2'b11, 16'h3322);
    send_beat(2'b11, 16'h5544);
    checks++; if (core_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL t1_valid_early got=%b exp=0", core_valid_o); end
    send_beat(2'b11, 16'h7766);
    checks++; if (core_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL t1_valid got=%b exp=1", core_valid_o); end
    checks++; if (core_data_o !== 64'h7766554433221100) begin failures++; $display("[TB] FAIL t1_data got=%h exp=7766554433221100", core_data_o); end
    tick();
    checks++; if (core_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL t1_popped got=%b exp=0", core_valid_o); end
    checks++; if (io_token_o !== 1'b0) begin failures++; $display("[TB] FAIL t1_no_token_first got=%b exp=0", io_token_o); end
    send_word(64'hFFEEDDCCBBAA9988);
    checks++; if (core_data_o !== 64'hFFEEDDCCBBAA9988) begin failures++; $display("[TB] FAIL t1_data2 got=%h exp=ffeeddccbbaa9988", core_data_o); end
    tick();
    checks++; if (io_token_o !== 1'b1) begin failures++; $display("[TB] FAIL t1_token got=%b exp=1", io_token_o); end
    tick();
    checks++; if (io_token_o !== 1'b0) begin failures++; $display("[TB] FAIL t1_token_width got=%b exp=0", io_token_o); end
    core_ready_i = 1'b0;
  endtask

  task automatic test_overflow;
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_word(word_of(i));
      checks++;
      if (core_valid_o !== 1'b1 || core_data_o !== word_of(0)) begin
        failures++; $display("[TB] FAIL t2_head_stable word=%0d got=%b/%h exp=1/%h", i, core_valid_o, core_data_o, word_of(0));
      end
    end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL t2_no_overflow got=%b exp=0", overflow_o); end
    send_word(word_of(8));
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL t2_overflow got=%b exp=1", overflow_o); end
    checks++; if (core_data_o !== word_of(0)) begin failures++; $display("[TB] FAIL t2_head_after_ovf got=%h exp=%h", core_data_o, word_of(0)); end
    core_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (core_valid_o !== 1'b1 || core_data_o !== word_of(i)) begin
        failures++; $display("[TB] FAIL t2_drain idx=%0d got=%b/%h exp=1/%h", i, core_valid_o, core_data_o, word_of(i));
      end
      tick();
      if (io_token_o === 1'b1) pulses++;
    end
    core_ready_i = 1'b0;
    checks++; if (core_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL t2_dropped_absent got=%b/%h exp=0", core_valid_o, core_data_o); end
    tick();
    if (io_token_o === 1'b1) pulses++;
    checks++; if (pulses != 4) begin failures++; $display("[TB] FAIL t2_token_count got=%0d exp=4", pulses); end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL t2_overflow_sticky got=%b exp=1", overflow_o); end
  endtask

  task automatic test_full_push_pop;
    logic [63:0] w;
    do_reset();
    for (int i = 0; i < 8; i++) send_word(word_of(10 + i));
    w = word_of(20);
    send_beat(2'b11, w[15:0]);
    send_beat(2'b11, w[31:16]);
    send_beat(2'b11, w[47:32]);
    core_ready_i = 1'b1;
    send_beat(2'b11, w[63:48]);
    core_ready_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL t3_no_overflow got=%b exp=0", overflow_o); end
    checks++; if (core_data_o !== word_of(11)) begin failures++; $display("[TB] FAIL t3_head got=%h exp=%h", core_data_o, word_of(11)); end
    send_word(word_of(30));
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL t3_still_full got=%b exp=1", overflow_o); end
    core_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = (i < 7) ? word_of(11 + i) : word_of(20);
      checks++;
      if (core_valid_o !== 1'b1 || core_data_o !== w) begin
        failures++; $display("[TB] FAIL t3_order idx=%0d got=%b/%h exp=1/%h", i, core_valid_o, core_data_o, w);
      end
      tick();
    end
    core_ready_i = 1'b0;
    checks++; if (core_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL t3_empty got=%b exp=0", core_valid_o); end
  endtask

  task automatic test_lane_error;
    do_reset();
    checks++; if (lane_err_o !== 1'b0) begin failures++; $display("[TB] FAIL t4_err_clear got=%b exp=0", lane_err_o); end
    send_beat(2'b11, 16'h1100);
    send_beat(2'b01, 16'hDEAD);
    checks++; if (lane_err_o !== 1'b1) begin failures++; $display("[TB] FAIL t4_err_set got=%b exp=1", lane_err_o); end
    send_beat(2'b11, 16'h3322);
    send_beat(2'b11, 16'h5544);
    checks++; if (core_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL t4_ctr_held got=%b exp=0", core_valid_o); end
    send_beat(2'b11, 16'h7766);
    checks++; if (core_valid_o !== 1'b1 || core_data_o !== 64'h7766554433221100) begin
      failures++; $display("[TB] FAIL t4_word got=%b/%h exp=1/7766554433221100", core_valid_o, core_data_o);
    end
    checks++; if (lane_err_o !== 1'b1) begin failures++; $display("[TB] FAIL t4_err_sticky got=%b exp=1", lane_err_o); end
  endtask

  task automatic test_mid_word_reset;
    send_beat(2'b11, 16'hAAAA);
    send_beat(2'b11, 16'hBBBB);
    rst = 1'b1;
    tick();
    checks++; if ({core_valid_o, io_token_o, lane_err_o, overflow_o} !== 4'b0000 || core_data_o !== 64'h0) begin
      failures++; $display("[TB] FAIL t5_reset_outputs got=%b%b%b%b/%h exp=0000/0", core_valid_o, io_token_o, lane_err_o, overflow_o, core_data_o);
    end
    rst = 1'b0;
    send_word(64'h0123456789ABCDEF);
    checks++; if (core_valid_o !== 1'b1 || core_data_o !== 64'h0123456789ABCDEF) begin
      failures++; $display("[TB] FAIL t5_clean_word got=%b/%h exp=1/0123456789abcdef", core_valid_o, core_data_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] w;
    int pulses = 0;
    int seen = 0;
    do_reset();
    core_ready_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      w = word_of(40 + n);
      for (int k = 0; k < 4; k++) begin
        if (n < 6) send_beat(2'b11, w[k*16 +: 16]);
        else tick();
        if (io_token_o === 1'b1) pulses++;
        if (core_valid_o === 1'b1) begin
          checks++;
          if (core_data_o !== word_of(40 + seen)) begin
            failures++; $display("[TB] FAIL t6_data idx=%0d got=%h exp=%h", seen, core_data_o, word_of(40 + seen));
          end
          seen++;
        end
      end
    end
    core_ready_i = 1'b0;
    checks++; if (seen != 6) begin failures++; $display("[TB] FAIL t6_word_count got=%0d exp=6", seen); end
    checks++; if (pulses != 3) begin failures++; $display("[TB] FAIL t6_token_count got=%0d exp=3", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_overflow();
    test_full_push_pop();
    test_lane_error();
    test_mid_word_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
